dvp_tx_16_8bit: RTL and testbench



---
 rtl/dvp_tx_16_8bit.sv | 174 +++++++++++++++++
 tb/tb_dvp_tx_16_8bit.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/dvp_tx_16_8bit.sv
// Camera-side DVP transmitter: serialises an RGB565 pixel stream into OV5640-style
// vsync/href/8-bit data, two bytes per pixel with the high byte first.
module dvp_tx_16_8bit #(
    parameter int   H_ACTIVE = 800,
    parameter int   V_ACTIVE = 480,
    parameter int   H_BLANK  = 64,
    parameter int   VS_LEN   = 4,
    parameter int   V_BACK   = 8,
    parameter int   V_FRONT  = 4,
    parameter logic VS_POL   = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic [15:0] pix_data,
    input  logic        pix_valid,
    output logic        pix_ready,
    output logic        cmos_vsync,
    output logic        cmos_href,
    output logic [7:0]  cmos_db,
    output logic        underflow,
    output logic        frame_done,
    output logic        busy
);

    localparam int LINE_CYC  = 2 * H_ACTIVE + H_BLANK;
    localparam int COL_W     = (LINE_CYC > 1) ? $clog2(LINE_CYC + 1) : 1;
    localparam int MAX_A     = (VS_LEN > V_BACK) ? VS_LEN : V_BACK;
    localparam int MAX_B     = (V_ACTIVE > V_FRONT) ? V_ACTIVE : V_FRONT;
    localparam int MAX_LINES = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int LINE_W    = (MAX_LINES > 1) ? $clog2(MAX_LINES + 1) : 1;

    localparam logic [COL_W-1:0]  COL_LAST     = COL_W'(LINE_CYC - 1);
    localparam logic [COL_W-1:0]  COL_HREF_END = COL_W'(2 * H_ACTIVE);
    localparam logic [LINE_W-1:0] VS_LAST      = LINE_W'(VS_LEN - 1);
    localparam logic [LINE_W-1:0] VBACK_LAST   = LINE_W'(V_BACK - 1);
    localparam logic [LINE_W-1:0] ACTIVE_LAST  = LINE_W'(V_ACTIVE - 1);
    localparam logic [LINE_W-1:0] VFRONT_LAST  = LINE_W'(V_FRONT - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_VSYNC,
        ST_VBACK,
        ST_ACTIVE,
        ST_VFRONT
    } state_t;

    state_t              state_reg, state_next;
    logic [COL_W-1:0]    col_reg, col_next;
    logic [LINE_W-1:0]   line_reg, line_next;
    logic [7:0]          pix_lo_reg, pix_lo_next;
    logic                vsync_reg, vsync_next;
    logic                href_reg, href_next;
    logic [7:0]          db_reg, db_next;
    logic                underflow_reg, underflow_next;
    logic                frame_done_reg, frame_done_next;
    logic                busy_reg, busy_next;

    logic [LINE_W-1:0]   line_last;
    logic                col_end;
    logic                line_end;
    logic                in_bytes;
    logic                pix_slot;

    // Line count of the current vertical region.
    always_comb begin
        line_last = '0;
        case (state_reg)
            ST_VSYNC:  line_last = VS_LAST;
            ST_VBACK:  line_last = VBACK_LAST;
            ST_ACTIVE: line_last = ACTIVE_LAST;
            ST_VFRONT: line_last = VFRONT_LAST;
            default:   line_last = '0;
        endcase
    end

    assign col_end  = (col_reg == COL_LAST);
    assign line_end = col_end && (line_reg == line_last);
    assign in_bytes = (state_reg == ST_ACTIVE) && (col_reg < COL_HREF_END);
    // Even byte columns are pixel slots: the pixel taken here leaves as the high byte next edge.
    assign pix_slot  = in_bytes && !col_reg[0];
    assign pix_ready = pix_slot;

    // Next-state and counters.
    always_comb begin
        state_next = state_reg;
        col_next   = col_reg;
        line_next  = line_reg;
        case (state_reg)
            ST_IDLE: begin
                col_next  = '0;
                line_next = '0;
                if (en) begin
                    state_next = ST_VSYNC;
                end
            end
            default: begin
                if (col_end) begin
                    col_next  = '0;
                    line_next = line_end ? '0 : line_reg + LINE_W'(1);
                end else begin
                    col_next = col_reg + COL_W'(1);
                end
                if (line_end) begin
                    case (state_reg)
                        ST_VSYNC:  state_next = ST_VBACK;
                        ST_VBACK:  state_next = ST_ACTIVE;
                        ST_ACTIVE: state_next = ST_VFRONT;
                        ST_VFRONT: state_next = en ? ST_VSYNC : ST_IDLE;
                        default:   state_next = ST_IDLE;
                    endcase
                end
            end
        endcase
    end

    // Registered outputs, computed from the current state and the slot decision.
    always_comb begin
        vsync_next      = (state_reg == ST_VSYNC) ? VS_POL : ~VS_POL;
        href_next       = in_bytes;
        db_next         = 8'h00;
        pix_lo_next     = pix_lo_reg;
        underflow_next  = 1'b0;
        frame_done_next = (state_reg == ST_VFRONT) && line_end;
        busy_next       = (state_reg != ST_IDLE);
        if (pix_slot) begin
            // A missing pixel still burns its slot so line timing never slips.
            if (pix_valid) begin
                db_next     = pix_data[15:8];
                pix_lo_next = pix_data[7:0];
            end else begin
                db_next        = 8'h00;
                pix_lo_next    = 8'h00;
                underflow_next = 1'b1;
            end
        end else if (in_bytes) begin
            db_next = pix_lo_reg;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= ST_IDLE;
            col_reg        <= '0;
            line_reg       <= '0;
            pix_lo_reg     <= 8'h00;
            vsync_reg      <= ~VS_POL;
            href_reg       <= 1'b0;
            db_reg         <= 8'h00;
            underflow_reg  <= 1'b0;
            frame_done_reg <= 1'b0;
            busy_reg       <= 1'b0;
        end else begin
            state_reg      <= state_next;
            col_reg        <= col_next;
            line_reg       <= line_next;
            pix_lo_reg     <= pix_lo_next;
            vsync_reg      <= vsync_next;
            href_reg       <= href_next;
            db_reg         <= db_next;
            underflow_reg  <= underflow_next;
            frame_done_reg <= frame_done_next;
            busy_reg       <= busy_next;
        end
    end

    assign cmos_vsync = vsync_reg;
    assign cmos_href  = href_reg;
    assign cmos_db    = db_reg;
    assign underflow  = underflow_reg;
    assign frame_done = frame_done_reg;
    assign busy       = busy_reg;

endmodule

// File: tb/tb_dvp_tx_16_8bit.sv
// Directed bench for dvp_tx_16_8bit: two instances (VS_POL=1 and VS_POL=0) share stimulus
// and are compared cycle by cycle against hand-derived frame timing.
module tb_dvp_tx_16_8bit;

    localparam int H_ACTIVE = 4;
    localparam int V_ACTIVE = 2;
    localparam int H_BLANK  = 3;
    localparam int VS_LEN   = 1;
    localparam int V_BACK   = 1;
    localparam int V_FRONT  = 1;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic [15:0] pix_data;
    logic        pix_valid;

    logic        pix_ready_a, vsync_a, href_a, underflow_a, frame_done_a, busy_a;
    logic [7:0]  db_a;
    logic        pix_ready_b, vsync_b, href_b, underflow_b, frame_done_b, busy_b;
    logic [7:0]  db_b;

    int n_checks  = 0;
    int n_pass    = 0;
    int src_k     = 0;
    int n_acc     = 0;
    int n_slot    = 0;
    int drop_slot = -1;

    always #5 clk = ~clk;

    dvp_tx_16_8bit #(
        .H_ACTIVE(H_ACTIVE), .V_ACTIVE(V_ACTIVE), .H_BLANK(H_BLANK),
        .VS_LEN(VS_LEN), .V_BACK(V_BACK), .V_FRONT(V_FRONT), .VS_POL(1'b1)
    ) dut_a (
        .clk(clk), .rst(rst), .en(en), .pix_data(pix_data), .pix_valid(pix_valid),
        .pix_ready(pix_ready_a), .cmos_vsync(vsync_a), .cmos_href(href_a),
        .cmos_db(db_a), .underflow(underflow_a), .frame_done(frame_done_a), .busy(busy_a)
    );

    dvp_tx_16_8bit #(
        .H_ACTIVE(H_ACTIVE), .V_ACTIVE(V_ACTIVE), .H_BLANK(H_BLANK),
        .VS_LEN(VS_LEN), .V_BACK(V_BACK), .V_FRONT(V_FRONT), .VS_POL(1'b0)
    ) dut_b (
        .clk(clk), .rst(rst), .en(en), .pix_data(pix_data), .pix_valid(pix_valid),
        .pix_ready(pix_ready_b), .cmos_vsync(vsync_b), .cmos_href(href_b),
        .cmos_db(db_b), .underflow(underflow_b), .frame_done(frame_done_b), .busy(busy_b)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] hi_byte(input int k);
        return 8'((161 + 34 * k) % 256);   // A1, C3, E5, ...
    endfunction

    function automatic logic [7:0] lo_byte(input int k);
        return 8'((178 + 34 * k) % 256);   // B2, D4, F6, ...
    endfunction

    // Output vector with vsync expressed as "active" so both polarities compare alike.
    function automatic logic [13:0] vec_a();
        return {vsync_a, href_a, busy_a, frame_done_a, underflow_a, pix_ready_a, db_a};
    endfunction

    function automatic logic [13:0] vec_b();
        return {~vsync_b, href_b, busy_b, frame_done_b, underflow_b, pix_ready_b, db_b};
    endfunction

    // Expected vector at cycle c of a frame whose enabling edge is cycle 0 (LINE_CYC = 11).
    function automatic logic [13:0] expv(input int c, input int drop, input int base_k, input int rst_c);
        logic vs, hr, bz, fd, uf, rd;
        logic [7:0] db;
        int p, s, k;
        vs = (c >= 1 && c <= 11);
        bz = (c >= 1 && c <= 55);
        fd = (c == 55);
        hr = 1'b0;
        uf = 1'b0;
        rd = 1'b0;
        db = 8'h00;
        for (int l = 0; l < 2; l++) begin
            if (c >= 22 + 11 * l && c < 30 + 11 * l && ((c - 22 - 11 * l) % 2 == 0)) rd = 1'b1;
            if (c >= 23 + 11 * l && c < 31 + 11 * l) begin
                hr = 1'b1;
                p  = c - 23 - 11 * l;
                s  = 4 * l + p / 2;
                if (s == drop) begin
                    uf = (p % 2 == 0);
                end else begin
                    k  = base_k + s - ((drop >= 0 && s > drop) ? 1 : 0);
                    db = (p % 2 == 0) ? hi_byte(k) : lo_byte(k);
                end
            end
        end
        if (rst_c >= 0 && c > rst_c) {vs, hr, bz, fd, uf, rd, db} = '0;
        return {vs, hr, bz, fd, uf, rd, db};
    endfunction

    // One clock: the FWFT source advances only on an accepted pixel.
    task automatic step();
        logic rdy, acc;
        rdy = pix_ready_a;
        acc = rdy && pix_valid;
        @(posedge clk);
        #1;
        if (acc) begin
            src_k++;
            n_acc++;
        end
        if (rdy) n_slot++;
        pix_valid = (n_slot != drop_slot);
        pix_data  = pix_valid ? {hi_byte(src_k), lo_byte(src_k)} : 16'hDEAD;
    endtask

    task automatic run_frame(input string name, input int first_c, input int last_c,
                             input int base_k, input int drop, input int rst_c, input int en_off_c);
        logic [13:0] e;
        n_slot    = 0;
        n_acc     = 0;
        drop_slot = drop;
        pix_valid = (drop != 0);
        pix_data  = pix_valid ? {hi_byte(src_k), lo_byte(src_k)} : 16'hDEAD;
        for (int c = first_c; c <= last_c; c++) begin
            step();
            e = expv(c, drop, base_k, rst_c);
            check_eq($sformatf("%s_pol1 c=%0d", name, c), 32'(vec_a()), 32'(e));
            check_eq($sformatf("%s_pol0 c=%0d", name, c), 32'(vec_b()), 32'(e));
            if (c == en_off_c) en = 1'b0;
            if (c == rst_c) rst = 1'b1;
        end
        $display("frame %s: cycles %0d..%0d, %0d pixels accepted over %0d slots",
                 name, first_c, last_c, n_acc, n_slot);
    endtask

    initial begin
        rst       = 1'b1;
        en        = 1'b0;
        pix_valid = 1'b0;
        pix_data  = 16'h0000;
        repeat (3) step();
        check_eq("reset_pol1", 32'(vec_a()), 32'(expv(-1, -1, 0, -1)));
        check_eq("reset_pol0", 32'(vec_b()), 32'(expv(-1, -1, 0, -1)));
        check_eq("reset_vsync_raw_pol0", 32'(vsync_b), 32'd1);
        rst = 1'b0;
        repeat (3) step();
        check_eq("idle_no_en", 32'(vec_a()), 32'(expv(-1, -1, 0, -1)));

        // Frame A: always-valid source; frame B: back-to-back, slot 2 starved, en dropped in ACTIVE.
        src_k = 0;
        en    = 1'b1;
        run_frame("A", 0, 55, 0, -1, -1, -1);
        check_eq("A_pixels_accepted", 32'(n_acc), 32'd8);
        check_eq("A_slots", 32'(n_slot), 32'd8);
        run_frame("B", 1, 60, 8, 2, -1, 25);
        check_eq("B_pixels_accepted", 32'(n_acc), 32'd7);
        check_eq("B_slots", 32'(n_slot), 32'd8);
        check_eq("B_idle_vsync_raw_pol1", 32'(vsync_a), 32'd0);

        // Reset mid-line, then re-enable straight out of reset.
        src_k = 0;
        en    = 1'b1;
        run_frame("R", 0, 26, 0, -1, 25, -1);
        rst   = 1'b0;
        src_k = 0;
        run_frame("C", 0, 55, 0, -1, -1, -1);
        check_eq("C_pixels_accepted", 32'(n_acc), 32'd8);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
